// File: rtl/racer_pkg.sv
// Shared constants for the LED racer game core: player indices, controller
// state encoding and winner codes.
package racer_pkg;

  localparam int NB_PLAYERS = 4;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  localparam logic [2:0] WIN_NONE   = 3'd0;

  // Winner code is the player index plus one, so zero can mean "no winner".
  function automatic logic [2:0] winner_code(input logic [1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/race_move_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: the first pending player at or after rr_ptr,
// wrapping modulo four. Purely combinational.
module rr_arbiter4
  import racer_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    any       = |pending;
    // Walk from the farthest offset down so the nearest pending player wins.
    for (int k = NB_PLAYERS - 1; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (pending[cand]) grant_idx = cand;
    end
    grant = any ? (4'b0001 << grant_idx) : 4'b0000;
  end

endmodule

// File: rtl/race_move_scheduler.sv
// LED racer game core: button edge capture, round-robin move scheduling,
// position counters, frame refresh sequencing and winner detection.
module race_move_scheduler
  import racer_pkg::*;
#(
  parameter int NB_LEDS = 49,
  parameter int POS_W   = 6
) (
  input  logic             clk,
  input  logic             FORCE_RESET_N,
  input  logic             GREEN_BTN,
  input  logic             RED_BTN,
  input  logic             BLUE_BTN,
  input  logic             YELLOW_BTN,
  input  logic             frame_busy,
  output logic             update_frame,
  output logic [3:0]       grant,
  output logic [POS_W-1:0] pos_green,
  output logic [POS_W-1:0] pos_red,
  output logic [POS_W-1:0] pos_blue,
  output logic [POS_W-1:0] pos_yellow,
  output logic [2:0]       winner
);

  logic [3:0]       btn, btn_prev, rise;
  logic [3:0]       pending;
  logic [1:0]       rr_ptr;
  logic [2:0]       state;
  logic [POS_W-1:0] pos_q [NB_PLAYERS];

  logic [3:0] arb_grant;
  logic [1:0] arb_idx;
  logic       arb_any;
  logic       do_move;
  logic [3:0] clr;

  assign btn  = {YELLOW_BTN, BLUE_BTN, RED_BTN, GREEN_BTN};
  assign rise = btn & ~btn_prev;

  rr_arbiter4 u_arb (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign do_move = (state == ST_RUN) && (winner == WIN_NONE) && arb_any;
  assign clr     = do_move ? arb_grant : 4'b0000;

  // Set wins over clear so a press landing on its own grant cycle is kept.
  always_ff @(posedge clk or negedge FORCE_RESET_N) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!FORCE_RESET_N) begin
      btn_prev <= '0;
      pending  <= '0;
    end else begin
      btn_prev <= btn;
      pending  <= (state == ST_FINISH) ? 4'b0000 : ((pending & ~clr) | rise);
    end
  end

  always_ff @(posedge clk or negedge FORCE_RESET_N) begin
    if (!FORCE_RESET_N) begin
      state        <= ST_INIT;
      rr_ptr       <= '0;
      grant        <= '0;
      update_frame <= 1'b0;
      winner       <= WIN_NONE;
      for (int i = 0; i < NB_PLAYERS; i++) pos_q[i] <= '0;
    end else begin
      grant        <= '0;
      update_frame <= 1'b0;
      case (state)
        ST_INIT:    state <= ST_REQ;
        ST_REQ: begin
          if (!frame_busy) begin
            update_frame <= 1'b1;
            state        <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: if (frame_busy)  state <= ST_WAIT_LO;
        ST_WAIT_LO: if (!frame_busy) state <= ST_RUN;
        ST_RUN: begin
          if (winner != WIN_NONE) begin
            state <= ST_FINISH;
          end else if (arb_any) begin
            grant          <= arb_grant;
            pos_q[arb_idx] <= pos_q[arb_idx] + POS_W'(1);
            rr_ptr         <= arb_idx + 2'd1;
            if (pos_q[arb_idx] == POS_W'(NB_LEDS - 2)) winner <= winner_code(arb_idx);
            state          <= ST_REQ;
          end
        end
        ST_FINISH:  state <= ST_FINISH;
        default:    state <= ST_INIT;
      endcase
    end
  end

  assign pos_green  = pos_q[GREEN];
  assign pos_red    = pos_q[RED];
  assign pos_blue   = pos_q[BLUE];
  assign pos_yellow = pos_q[YELLOW];

endmodule
